// File: rtl/nand_share_arbiter.sv
// Round-robin arbiter sharing one registered NAND unit between N_REQ requesters.
// One op in flight; valid/ready on every requester and on the response port.
module nand_share_arbiter #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 8,
   parameter int LAT   = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           req_valid,
   input  logic [N_REQ*WIDTH-1:0]     req_a,
   input  logic [N_REQ*WIDTH-1:0]     req_b,
   output logic [N_REQ-1:0]           req_ready,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [WIDTH-1:0]           rsp_data,
   output logic [$clog2(N_REQ)-1:0]   rsp_id,
   output logic                       busy,
   output logic [15:0]                op_count
);

   localparam int IDW = $clog2(N_REQ);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [IDW-1:0]   rr_ptr;
   logic             gnt_vld;
   logic [IDW-1:0]   gnt_id;
   logic [IDW-1:0]   rr_nxt;
   logic [3:0]       lat_cnt;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [IDW-1:0]   id_q;
   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_b;
   logic             hs_req;
   logic             hs_rsp;
   logic             rsp_load;
   int               idx;

   // Walk downward so the lowest offset from rr_ptr wins.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_id  = '0;
      idx     = 0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = int'(rr_ptr) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (req_valid[idx]) begin
            gnt_vld = 1'b1;
            gnt_id  = IDW'(idx);
         end
      end
   end

   assign rr_nxt = (int'(gnt_id) == N_REQ - 1) ? '0 : gnt_id + 1'b1;
   assign sel_a  = req_a[int'(gnt_id)*WIDTH +: WIDTH];
   assign sel_b  = req_b[int'(gnt_id)*WIDTH +: WIDTH];
   assign hs_req = |(req_valid & req_ready);
   assign hs_rsp = rsp_valid & rsp_ready;
   assign rsp_load = (state_nxt == RESP) && (state != RESP);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (hs_req) state_nxt = (LAT == 1) ? RESP : BUSY;
         BUSY: if (lat_cnt <= 4'd1) state_nxt = RESP;
         RESP: if (hs_rsp) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req_ready = '0;
      if (!rst && state == IDLE && gnt_vld) req_ready[gnt_id] = 1'b1;
      busy = (state != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= '0;
         lat_cnt <= '0;
         a_q <= '0;
         b_q <= '0;
         id_q <= '0;
      end else if (hs_req) begin
         rr_ptr <= rr_nxt;
         lat_cnt <= 4'(LAT - 1);
         a_q <= sel_a;
         b_q <= sel_b;
         id_q <= gnt_id;
      end else if (state == BUSY) begin
         lat_cnt <= lat_cnt - 4'd1;
      end
   end

   // LAT=1 jumps straight to RESP, so take operands from the live bus.
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid <= 1'b0;
         rsp_data <= '0;
         rsp_id <= '0;
         op_count <= '0;
      end else begin
         if (rsp_load) begin
            rsp_valid <= 1'b1;
            rsp_data <= (state == IDLE) ? ~(sel_a & sel_b) : ~(a_q & b_q);
            rsp_id <= (state == IDLE) ? gnt_id : id_q;
         end else if (hs_rsp) begin
            rsp_valid <= 1'b0;
         end
         if (hs_rsp) op_count <= op_count + 16'd1;
      end
   end

endmodule
